ccr_flag_unit: RTL and testbench

//  Owns the 4-bit condition code register {V,C,N,Z} that feeds the ALU CCR input and captures
//  the ALU's new Z/N/C/V outputs each cycle. Sits beside the EX stage.
//  - merges masked flag writes
//  - clears the tested flag when a conditional jump is taken
//  - saves/restores CCR on interrupt entry/RTI through a LIFO shadow stack (nested interrupts)
//  - provides a combinational forward of next-CCR for back-to-back flag-dependent instructions

---
 rtl/ccr_flag_unit.sv | 105 ++++++++++
 tb/tb_ccr_flag_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccr_flag_unit.sv
// Condition code register {V,C,N,Z} beside the EX stage: masked ALU flag merge, jump-taken
// flag clear, LIFO shadow stack for nested interrupt save/restore, and a next-CCR forward.
module ccr_flag_unit #(
    parameter int SHADOW_DEPTH = 2,
    parameter int DEPTH_W      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_z,
    input  logic               alu_n,
    input  logic               alu_c,
    input  logic               alu_v,
    input  logic               flag_we,
    input  logic [3:0]         flag_mask,
    input  logic               jmp_taken,
    input  logic [1:0]         jmp_cond,
    input  logic               int_save,
    input  logic               rti_restore,
    input  logic               err_clr,
    output logic [3:0]         ccr,
    output logic [3:0]         ccr_next,
    output logic [DEPTH_W-1:0] depth,
    output logic               in_isr,
    output logic               shadow_full,
    output logic               err_overflow,
    output logic               err_underflow
);

    logic [3:0] slot [SHADOW_DEPTH];
    logic [3:0] upd;
    logic [3:0] pop_val;
    logic       push_ok;
    logic       pop_ok;
    logic       ovf_evt;
    logic       unf_evt;

    function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                               input logic [3:0] alu,
                                               input logic [3:0] mask);
        return (cur & ~mask) | (alu & mask);
    endfunction

    function automatic logic [3:0] clear_tested(input logic [3:0] f,
                                                input logic [1:0] cond);
        logic [3:0] r;
        r       = f;
        r[cond] = 1'b0;
        return r;
    endfunction

    assign in_isr      = (depth != '0);
    assign shadow_full = (depth == DEPTH_W'(SHADOW_DEPTH));

    always_comb begin
        upd = merge_flags(ccr, {alu_v, alu_c, alu_n, alu_z},
                          flag_we ? flag_mask : 4'b0000);
        // The jump clear is applied after the merge so it wins over a write to the same bit.
        if (jmp_taken)
            upd = clear_tested(upd, jmp_cond);

        pop_val = '0;
        for (int i = 0; i < SHADOW_DEPTH; i++)
            if (depth == DEPTH_W'(i + 1))
                pop_val = slot[i];

        // Simultaneous save and restore is a net-zero nesting change: no stack or error activity.
        push_ok  = int_save & ~rti_restore & ~shadow_full;
        pop_ok   = rti_restore & ~int_save & in_isr;
        ovf_evt  = int_save & ~rti_restore & shadow_full;
        unf_evt  = rti_restore & ~int_save & ~in_isr;
        ccr_next = pop_ok ? pop_val : upd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr           <= '0;
            depth         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++)
                slot[i] <= '0;
        end else begin
            ccr <= ccr_next;
            if (push_ok) begin
                for (int i = 0; i < SHADOW_DEPTH; i++)
                    if (depth == DEPTH_W'(i))
                        slot[i] <= upd;
                depth <= depth + DEPTH_W'(1);
            end else if (pop_ok) begin
                depth <= depth - DEPTH_W'(1);
            end

            if (ovf_evt)
                err_overflow <= 1'b1;
            else if (err_clr)
                err_overflow <= 1'b0;

            if (unf_evt)
                err_underflow <= 1'b1;
            else if (err_clr)
                err_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Bench for ccr_flag_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_ccr_flag_unit;

    logic       clk;
    logic       rst_n;
    logic       alu_z, alu_n, alu_c, alu_v;
    logic       flag_we;
    logic [3:0] flag_mask;
    logic       jmp_taken;
    logic [1:0] jmp_cond;
    logic       int_save;
    logic       rti_restore;
    logic       err_clr;
    logic [3:0] ccr;
    logic [3:0] ccr_next;
    logic [1:0] depth;
    logic       in_isr;
    logic       shadow_full;
    logic       err_overflow;
    logic       err_underflow;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [3:0] m_ccr;
    logic [3:0] m_stack[$];
    logic       m_of;
    logic       m_uf;

    ccr_flag_unit #(.SHADOW_DEPTH(2), .DEPTH_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .flag_we(flag_we), .flag_mask(flag_mask),
        .jmp_taken(jmp_taken), .jmp_cond(jmp_cond),
        .int_save(int_save), .rti_restore(rti_restore), .err_clr(err_clr),
        .ccr(ccr), .ccr_next(ccr_next), .depth(depth), .in_isr(in_isr),
        .shadow_full(shadow_full), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_alu(input logic [3:0] f);
        {alu_v, alu_c, alu_n, alu_z} = f;
    endtask

    task automatic idle();
        set_alu(4'b0000);
        flag_we = 0; flag_mask = 4'b0000; jmp_taken = 0; jmp_cond = 2'b00;
        int_save = 0; rti_restore = 0; err_clr = 0;
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ccr(input logic [3:0] v);
        flag_we = 1; flag_mask = 4'b1111; set_alu(v);
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        #1;
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #1;
        checks++;
        if (ccr !== 4'b0000 || depth !== 2'd0 || in_isr !== 1'b0 || shadow_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ccr=%b depth=%0d in_isr=%b full=%b, want 0000/0/0/0",
                     ccr, depth, in_isr, shadow_full);
        end
        checks++;
        if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_errs: ovf=%b unf=%b, want 0/0", err_overflow, err_underflow);
        end
        tick();
        rst_n = 1;
    endtask

    task automatic test_flag_write();
        flag_we = 1; flag_mask = 4'b1111; set_alu(4'b0110);
        #1;
        checks++;
        if (ccr_next !== 4'b0110 || ccr !== 4'b0000) begin
            errors++;
            $display("FAIL write_forward: ccr_next=%b ccr=%b, want 0110/0000", ccr_next, ccr);
        end
        tick();
        idle();
        checks++;
        if (ccr !== 4'b0110) begin
            errors++;
            $display("FAIL write_latency: ccr=%b, want 0110", ccr);
        end
        // Zero mask with write enable leaves ccr alone
        flag_we = 1; flag_mask = 4'b0000; set_alu(4'b1001);
        tick();
        idle();
        checks++;
        if (ccr !== 4'b0110) begin
            errors++;
            $display("FAIL zero_mask: ccr=%b, want 0110", ccr);
        end
    endtask

    task automatic test_jump_clear();
        write_ccr(4'b1111);
        flag_we = 1; flag_mask = 4'b0001; set_alu(4'b0000);
        jmp_taken = 1; jmp_cond = 2'b10;
        tick();
        idle();
        checks++;
        if (ccr !== 4'b1010) begin
            errors++;
            $display("FAIL jump_clear: ccr=%b, want 1010", ccr);
        end
        // Clear wins over a write of 1 to the same bit
        flag_we = 1; flag_mask = 4'b1000; set_alu(4'b1000);
        jmp_taken = 1; jmp_cond = 2'b11;
        tick();
        idle();
        checks++;
        if (ccr !== 4'b0010) begin
            errors++;
            $display("FAIL jump_clear_wins: ccr=%b, want 0010", ccr);
        end
    endtask

    task automatic test_save_restore();
        do_reset();
        write_ccr(4'b0101);
        int_save = 1;
        tick();
        idle();
        checks++;
        if (depth !== 2'd1 || in_isr !== 1'b1 || ccr !== 4'b0101) begin
            errors++;
            $display("FAIL save: depth=%0d in_isr=%b ccr=%b, want 1/1/0101", depth, in_isr, ccr);
        end
        write_ccr(4'b0010);
        rti_restore = 1;
        #1;
        checks++;
        if (ccr_next !== 4'b0101) begin
            errors++;
            $display("FAIL restore_forward: ccr_next=%b, want 0101", ccr_next);
        end
        tick();
        idle();
        checks++;
        if (ccr !== 4'b0101 || depth !== 2'd0 || in_isr !== 1'b0) begin
            errors++;
            $display("FAIL restore: ccr=%b depth=%0d in_isr=%b, want 0101/0/0", ccr, depth, in_isr);
        end
    endtask

    task automatic test_nesting_overflow();
        logic [3:0] vals [3];
        vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            write_ccr(vals[i]);
            int_save = 1;
            tick();
            idle();
        end
        checks++;
        if (depth !== 2'd2 || shadow_full !== 1'b1 || err_overflow !== 1'b1 || ccr !== 4'b0100) begin
            errors++;
            $display("FAIL overflow: depth=%0d full=%b ovf=%b ccr=%b, want 2/1/1/0100",
                     depth, shadow_full, err_overflow, ccr);
        end
        rti_restore = 1;
        tick();
        idle();
        checks++;
        if (ccr !== 4'b0010 || depth !== 2'd1) begin
            errors++;
            $display("FAIL nested_rti1: ccr=%b depth=%0d, want 0010/1", ccr, depth);
        end
        rti_restore = 1;
        tick();
        idle();
        checks++;
        if (ccr !== 4'b0001 || depth !== 2'd0 || err_overflow !== 1'b1) begin
            errors++;
            $display("FAIL nested_rti2: ccr=%b depth=%0d ovf=%b, want 0001/0/1", ccr, depth, err_overflow);
        end
        err_clr = 1;
        tick();
        idle();
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, want 0", err_overflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        rti_restore = 1; flag_we = 1; flag_mask = 4'b1111; set_alu(4'b1000);
        tick();
        idle();
        checks++;
        if (ccr !== 4'b1000 || err_underflow !== 1'b1 || depth !== 2'd0) begin
            errors++;
            $display("FAIL underflow: ccr=%b unf=%b depth=%0d, want 1000/1/0", ccr, err_underflow, depth);
        end
        // Error event in the same cycle as err_clr keeps the bit set
        rti_restore = 1; err_clr = 1;
        tick();
        idle();
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_event_wins: unf=%b, want 1", err_underflow);
        end
        err_clr = 1;
        tick();
        idle();
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear: unf=%b, want 0", err_underflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_ccr(4'b0110);
        int_save = 1;
        tick();
        idle();
        int_save = 1; rti_restore = 1; flag_we = 1; flag_mask = 4'b1111; set_alu(4'b0011);
        tick();
        idle();
        checks++;
        if (depth !== 2'd1 || ccr !== 4'b0011 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL save_and_rti: depth=%0d ccr=%b ovf=%b unf=%b, want 1/0011/0/0",
                     depth, ccr, err_overflow, err_underflow);
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (ccr !== 4'b0000 || depth !== 2'd0 || in_isr !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mid_isr: ccr=%b depth=%0d in_isr=%b, want 0000/0/0",
                     ccr, depth, in_isr);
        end
        tick();
        rst_n = 1;
        rti_restore = 1;
        tick();
        idle();
        checks++;
        if (ccr !== 4'b0000 || err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL no_restore_after_reset: ccr=%b unf=%b, want 0000/1", ccr, err_underflow);
        end
    endtask

    task automatic test_random();
        logic [3:0] alu;
        logic [3:0] upd;
        logic [3:0] exp_next;
        logic       ev_of, ev_uf;
        do_reset();
        m_ccr = 4'b0000; m_stack.delete(); m_of = 0; m_uf = 0;
        for (int n = 0; n < 400; n++) begin
            alu         = 4'($urandom);
            set_alu(alu);
            flag_we     = 1'($urandom);
            flag_mask   = 4'($urandom);
            jmp_taken   = ($urandom_range(0, 2) == 0);
            jmp_cond    = 2'($urandom);
            int_save    = ($urandom_range(0, 3) == 0);
            rti_restore = ($urandom_range(0, 3) == 0);
            err_clr     = ($urandom_range(0, 7) == 0);

            upd = m_ccr;
            if (flag_we)
                for (int b = 0; b < 4; b++)
                    if (flag_mask[b]) upd[b] = alu[b];
            if (jmp_taken) upd[jmp_cond] = 1'b0;
            exp_next = upd;
            ev_of = 0; ev_uf = 0;
            if (int_save && rti_restore) begin
                exp_next = upd;
            end else if (rti_restore) begin
                if (m_stack.size() > 0) exp_next = m_stack.pop_back();
                else ev_uf = 1;
            end else if (int_save) begin
                if (m_stack.size() < 2) m_stack.push_back(upd);
                else ev_of = 1;
            end
            m_of = ev_of ? 1'b1 : (err_clr ? 1'b0 : m_of);
            m_uf = ev_uf ? 1'b1 : (err_clr ? 1'b0 : m_uf);
            m_ccr = exp_next;

            #1;
            checks++;
            if (ccr_next !== exp_next) begin
                errors++;
                $display("FAIL rand_ccr_next[%0d]: got %b, want %b", n, ccr_next, exp_next);
            end
            tick();
            idle();
            checks++;
            if (ccr !== m_ccr || depth !== 2'(m_stack.size()) || in_isr !== (m_stack.size() != 0) ||
                shadow_full !== (m_stack.size() == 2) || err_overflow !== m_of || err_underflow !== m_uf) begin
                errors++;
                $display("FAIL rand_state[%0d]: ccr=%b d=%0d isr=%b full=%b ovf=%b unf=%b, want %b/%0d/ovf=%b/unf=%b",
                         n, ccr, depth, in_isr, shadow_full, err_overflow, err_underflow,
                         m_ccr, m_stack.size(), m_of, m_uf);
            end
        end
    endtask

    initial begin
        rst_n = 1;
        idle();
        #2;
        test_reset();
        test_flag_write();
        test_jump_clear();
        test_save_restore();
        test_nesting_overflow();
        test_underflow();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
